// File: rtl/elev_pkg.sv
// Shared constants and types for the elevator request side.
package elev_pkg;

  localparam int unsigned FLOOR_W       = 2;
  localparam int unsigned NFLOORS       = 2 ** FLOOR_W;
  localparam int unsigned DWELL_DEFAULT = 4;

  typedef logic [FLOOR_W-1:0] floor_t;

  typedef enum logic [1:0] {
    IDLE,
    UP,
    DOWN,
    SERVE
  } state_t;

endpackage

// File: rtl/next_call_select.sv
// Combinational search of the pending set relative to the current floor:
// nearest call above, nearest call below, and whether the current floor is called.
module next_call_select
  import elev_pkg::*;
#(
  parameter int unsigned FLOOR_W = elev_pkg::FLOOR_W,
  parameter int unsigned NFLOORS = 2 ** FLOOR_W
) (
  input  logic [NFLOORS-1:0] pending,
  input  logic [FLOOR_W-1:0] floor,
  output logic               has_above,
  output logic [FLOOR_W-1:0] nearest_above,
  output logic               has_below,
  output logic [FLOOR_W-1:0] nearest_below,
  output logic               at_floor
);

  always_comb begin
    has_above     = 1'b0;
    nearest_above = '0;
    has_below     = 1'b0;
    nearest_below = '0;
    // Downward scan: the last hit above is the lowest pending floor above.
    for (int unsigned i = NFLOORS; i > 0; i--) begin
      if (pending[i-1] && (FLOOR_W'(i - 1) > floor)) begin
        has_above     = 1'b1;
        nearest_above = FLOOR_W'(i - 1);
      end
    end
    // Upward scan: the last hit below is the highest pending floor below.
    for (int unsigned i = 0; i < NFLOORS; i++) begin
      if (pending[i] && (FLOOR_W'(i) < floor)) begin
        has_below     = 1'b1;
        nearest_below = FLOOR_W'(i);
      end
    end
  end

  assign at_floor = pending[floor];

endmodule

// File: rtl/call_dispatcher.sv
// Request side of the 4-floor elevator: latches call presses, picks targets with a
// SCAN policy, holds the door for a dwell time and clears the served call.
module call_dispatcher
  import elev_pkg::*;
#(
  parameter int unsigned FLOOR_W = elev_pkg::FLOOR_W,
  parameter int unsigned NFLOORS = 2 ** FLOOR_W,
  parameter int unsigned DWELL   = elev_pkg::DWELL_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NFLOORS-1:0] btn,
  input  logic [FLOOR_W-1:0] floor_status,
  input  logic               door,
  output logic [FLOOR_W-1:0] calling_status,
  output logic [NFLOORS-1:0] pending,
  output logic               dir_up,
  output logic               busy,
  output logic               door_hold
);

  localparam int unsigned      CNT_W  = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DWELL - 1);

  state_t             state;
  logic [NFLOORS-1:0] btn_q;
  logic [NFLOORS-1:0] rise;
  logic [NFLOORS-1:0] clear_mask;
  logic [CNT_W-1:0]   cnt;

  logic               has_above;
  logic               has_below;
  logic               at_floor;
  logic [FLOOR_W-1:0] nearest_above;
  logic [FLOOR_W-1:0] nearest_below;

  logic serve_here;
  logic arrived;
  logic reload;
  logic serve_done;

  next_call_select #(
    .FLOOR_W (FLOOR_W),
    .NFLOORS (NFLOORS)
  ) u_select (
    .pending       (pending),
    .floor         (floor_status),
    .has_above     (has_above),
    .nearest_above (nearest_above),
    .has_below     (has_below),
    .nearest_below (nearest_below),
    .at_floor      (at_floor)
  );

  always_comb begin
    rise       = btn & ~btn_q;
    serve_here = door & at_floor;
    arrived    = at_floor & (floor_status == calling_status);
    reload     = (state == SERVE) & rise[floor_status];
    serve_done = (state == SERVE) & (cnt == '0) & ~reload;
    clear_mask = serve_done ? (NFLOORS'(1) << floor_status) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      calling_status <= '0;
      pending        <= '0;
      dir_up         <= 1'b1;
      busy           <= 1'b0;
      door_hold      <= 1'b0;
      btn_q          <= '0;
      cnt            <= '0;
    end else begin
      btn_q   <= btn;
      pending <= (pending & ~clear_mask) | rise;

      if ((state != SERVE) && serve_here) begin
        state          <= SERVE;
        cnt            <= RELOAD;
        calling_status <= floor_status;
        busy           <= 1'b1;
        door_hold      <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (pending != '0) begin
              if (has_above) begin
                state          <= UP;
                dir_up         <= 1'b1;
                busy           <= 1'b1;
                calling_status <= nearest_above;
              end else if (has_below) begin
                state          <= DOWN;
                dir_up         <= 1'b0;
                busy           <= 1'b1;
                calling_status <= nearest_below;
              end else begin
                calling_status <= floor_status;
              end
            end
          end

          // Once the car sits on a called target, hold it there until door arrives.
          UP: begin
            if (at_floor && (arrived || !has_above)) begin
              calling_status <= floor_status;
            end else if (has_above) begin
              calling_status <= nearest_above;
            end else if (has_below) begin
              state          <= DOWN;
              dir_up         <= 1'b0;
              calling_status <= nearest_below;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end

          DOWN: begin
            if (at_floor && (arrived || !has_below)) begin
              calling_status <= floor_status;
            end else if (has_below) begin
              calling_status <= nearest_below;
            end else if (has_above) begin
              state          <= UP;
              dir_up         <= 1'b1;
              calling_status <= nearest_above;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end

          // has_above/has_below never include the served floor, so they already
          // describe the pending set after this cycle's clear.
          SERVE: begin
            if (reload) begin
              cnt <= RELOAD;
            end else if (cnt != '0) begin
              cnt <= cnt - CNT_W'(1);
            end else begin
              door_hold <= 1'b0;
              if (dir_up && has_above) begin
                state <= UP;
              end else if (!dir_up && has_below) begin
                state <= DOWN;
              end else if (has_below) begin
                state  <= DOWN;
                dir_up <= 1'b0;
              end else if (has_above) begin
                state  <= UP;
                dir_up <= 1'b1;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_call_dispatcher.sv
// Directed bench for call_dispatcher: expected serves are queued by the stimulus
// and checked by an independent monitor watching door_hold.
module tb_call_dispatcher;
  import elev_pkg::*;

  typedef struct {
    floor_t floor;
    int     dwell;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   btn;
  floor_t       floor_status;
  logic         door;
  floor_t       calling_status;
  logic [3:0]   pending;
  logic         dir_up;
  logic         busy;
  logic         door_hold;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  exp_t cur;
  int   hold_len  = 0;
  logic hold_prev = 1'b0;
  logic have_cur  = 1'b0;

  always #5 clk = ~clk;

  call_dispatcher #(
    .FLOOR_W (2),
    .NFLOORS (4),
    .DWELL   (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .btn            (btn),
    .floor_status   (floor_status),
    .door           (door),
    .calling_status (calling_status),
    .pending        (pending),
    .dir_up         (dir_up),
    .busy           (busy),
    .door_hold      (door_hold)
  );

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_hold(input logic level, input int budget, input string name);
    int n = 0;
    while (door_hold !== level && n < budget) begin
      tick();
      n++;
    end
    check(name, door_hold, level);
  endtask

  task automatic wait_target(input floor_t f);
    int n = 0;
    while (calling_status !== f && n < 8) begin
      tick();
      n++;
    end
    check("target", calling_status, f);
  endtask

  // Car reaches floor f with the door registered; expect a full dwell there.
  task automatic visit(input floor_t f, input int dwell);
    wait_target(f);
    exp_q.push_back('{floor: f, dwell: dwell});
    floor_status = f;
    door         = 1'b1;
    wait_hold(1'b1, 8, "serve_start");
    wait_hold(1'b0, 20, "serve_end");
    door = 1'b0;
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (door_hold === 1'b1 && !hold_prev) begin
        hold_len = 1;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          have_cur = 1'b0;
          $display("FAIL unexpected_serve: door_hold rose with target %0d, expected no serve", calling_status);
        end else begin
          cur      = exp_q.pop_front();
          have_cur = 1'b1;
          check("serve_floor", calling_status, cur.floor);
        end
      end else if (door_hold === 1'b1) begin
        hold_len++;
      end else if (hold_prev && have_cur) begin
        check("dwell_len", hold_len, cur.dwell);
        check("served_bit_clear", pending[cur.floor], 1'b0);
        have_cur = 1'b0;
      end
      hold_prev = (door_hold === 1'b1);
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    reset        = 1'b1;
    btn          = '0;
    floor_status = 2'd2;
    door         = 1'b0;
    tick(2);

    // Reset state with the car reporting floor 2.
    check("rst_calling", calling_status, 2'd0);
    check("rst_pending", pending, 4'b0000);
    check("rst_busy", busy, 1'b0);
    check("rst_dir_up", dir_up, 1'b1);
    check("rst_door_hold", door_hold, 1'b0);

    // Single call from ground floor: pending +1, target +2, 4-cycle dwell.
    reset        = 1'b0;
    floor_status = 2'd0;
    tick();
    btn = 4'b0100;
    tick();
    btn = '0;
    check("t2_pending", pending, 4'b0100);
    check("t2_calling_early", calling_status, 2'd0);
    check("t2_busy_early", busy, 1'b0);
    tick();
    check("t2_calling", calling_status, 2'd2);
    check("t2_busy", busy, 1'b1);
    check("t2_dir_up", dir_up, 1'b1);
    visit(2'd2, 4);
    check("t2_pending_done", pending, 4'b0000);
    check("t2_idle", busy, 1'b0);

    // Sweep up from floor 1 towards 3, picking up 2 on the way, then reverse to 0.
    floor_status = 2'd1;
    btn          = 4'b1000;
    tick();
    btn = '0;
    tick();
    check("t3_calling3", calling_status, 2'd3);
    door = 1'b1;
    tick(3);
    check("t3_stale_door_no_serve", door_hold, 1'b0);
    check("t3_stale_door_target", calling_status, 2'd3);
    door = 1'b0;
    btn  = 4'b0101;
    tick();
    btn = '0;
    check("t3_pending", pending, 4'b1101);
    visit(2'd2, 4);
    visit(2'd3, 4);
    check("t3_reversed", dir_up, 1'b0);
    visit(2'd0, 4);
    tick();
    check("t3_idle", busy, 1'b0);
    check("t3_pending_done", pending, 4'b0000);

    // Held button registers once; it is not re-latched after its call is served.
    btn = 4'b0010;
    visit(2'd1, 4);
    tick(3);
    btn = '0;
    check("t4_held_no_relatch", pending, 4'b0000);
    tick();
    check("t4_held_idle", busy, 1'b0);

    // Re-press during the serve restarts the dwell: 2 cycles + 4 more.
    exp_q.push_back('{floor: 2'd1, dwell: 6});
    door = 1'b1;
    btn  = 4'b0010;
    tick();
    btn = '0;
    wait_hold(1'b1, 8, "t4_serve_start");
    tick();
    btn = 4'b0010;
    tick();
    btn = '0;
    wait_hold(1'b0, 20, "t4_serve_end");
    door = 1'b0;
    check("t4_cleared_once", pending, 4'b0000);
    tick();
    check("t4_stays_clear", pending, 4'b0000);
    check("t4_idle", busy, 1'b0);

    // Reset in the second SERVE cycle discards every call.
    btn = 4'b1001;
    tick();
    btn = '0;
    wait_target(2'd3);
    exp_q.push_back('{floor: 2'd3, dwell: 2});
    floor_status = 2'd3;
    door         = 1'b1;
    wait_hold(1'b1, 8, "t5_serve_start");
    tick();
    reset = 1'b1;
    tick();
    check("t5_pending", pending, 4'b0000);
    check("t5_busy", busy, 1'b0);
    check("t5_calling", calling_status, 2'd0);
    check("t5_door_hold", door_hold, 1'b0);
    check("t5_dir_up", dir_up, 1'b1);

    // All four buttons at once while parked at floor 1: order 1,2,3,0.
    reset        = 1'b0;
    floor_status = 2'd1;
    door         = 1'b1;
    btn          = 4'b1111;
    tick();
    btn = '0;
    check("t6_pending", pending, 4'b1111);
    exp_q.push_back('{floor: 2'd1, dwell: 4});
    wait_hold(1'b1, 8, "t6_serve1_start");
    wait_hold(1'b0, 20, "t6_serve1_end");
    door = 1'b0;
    check("t6_dir_after1", dir_up, 1'b1);
    visit(2'd2, 4);
    visit(2'd3, 4);
    check("t6_dir_after3", dir_up, 1'b0);
    visit(2'd0, 4);
    tick();
    check("t6_idle", busy, 1'b0);
    check("t6_pending_done", pending, 4'b0000);

    tick(2);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
